inst_fetch_unit: RTL and testbench

Instruction-fetch stage; the initiator side of the instruction memory interface. Owns the program counter and drives a word address into inst_mem, which returns the instruction combinationally in the same cycle. Registers instruction, PC and PC+4 into an IF/ID output register with a valid/ready handshake toward decode. Handles stall, branch/jump redirect with flush, and out-of-range fetch faults.

---
 rtl/if_pkg.sv | 18 +
 rtl/inst_fetch_unit_if.sv | 33 +++
 rtl/if_id_reg.sv | 42 ++++
 rtl/inst_fetch_unit.sv | 120 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM encoding and word sizing.
package if_pkg;

    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction memory port plus the IF/ID valid/ready output channel.
interface inst_fetch_unit_if;
    import if_pkg::*;

    logic [31:0]        imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [31:0]        out_pc;
    logic [31:0]        out_pc_plus4;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a new instruction, holds while stalled,
// drains on acceptance and clears on flush.
module if_id_reg
    import if_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic               ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [31:0]        in_pc,
    input  logic [31:0]        in_pc_plus4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4
);

    // Flush beats load; without a load an accepted entry drains, otherwise everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
        end else begin
            if (load) begin
                instr    <= in_instr;
                pc       <= in_pc;
                pc_plus4 <= in_pc_plus4;
            end
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (ready)
                valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, sequences fetches from inst_mem and
// feeds decode through the IF/ID register.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | fetch_en low; PC parked, held IF/ID entry may still drain
//   ST_RUN   | fetching one word per cycle when IF/ID has room
//   ST_FAULT | PC ran past inst_mem; waits for an in-range redirect
module inst_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64,
    parameter int          COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    inst_fetch_unit_if.master  bus,
    output logic               fault,
    output logic               misalign,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_DEPTH) * 33'(WORD_BYTES);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  tgt_aligned;
    logic         pc_in_range;
    logic         tgt_in_range;
    logic         load;
    logic         handshake;

    assign bus.imem_addr = pc;
    assign pc_plus4      = pc + 32'(WORD_BYTES);
    assign tgt_aligned   = word_align(redirect_target);
    assign pc_in_range   = {1'b0, pc} < IMEM_LIMIT;
    assign tgt_in_range  = {1'b0, tgt_aligned} < IMEM_LIMIT;
    assign handshake     = bus.out_valid && bus.out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and fetch decision; a redirect suppresses the fetch in its cycle.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch_en)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!fetch_en)
                    state_nxt = ST_IDLE;
                else if (redirect_valid)
                    state_nxt = ST_RUN;
                else if (!pc_in_range)
                    state_nxt = ST_FAULT;
                else if (!bus.out_valid || bus.out_ready)
                    load = 1'b1;
            end
            ST_FAULT: begin
                if (redirect_valid && tgt_in_range)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // PC, sticky fault, misalign pulse and retired-fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            fault       <= 1'b0;
            misalign    <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (redirect_valid)
                pc <= tgt_aligned;
            else if (load)
                pc <= pc_plus4;

            if (state == ST_RUN && state_nxt == ST_FAULT)
                fault <= 1'b1;
            else if (redirect_valid && tgt_in_range)
                fault <= 1'b0;

            misalign <= redirect_valid && (|redirect_target[1:0]);

            if (handshake)
                fetch_count <= fetch_count + COUNT_W'(1);
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .flush       (redirect_valid),
        .ready       (bus.out_ready),
        .in_instr    (bus.imem_instr),
        .in_pc       (pc),
        .in_pc_plus4 (pc_plus4),
        .valid       (bus.out_valid),
        .instr       (bus.out_instr),
        .pc          (bus.out_pc),
        .pc_plus4    (bus.out_pc_plus4)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench: a 64-word instance for sequencing, stall, redirect and reset,
// and an 8-word instance for the out-of-range fault path.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n, rst_n2;
    logic        fetch_en, fetch_en2;
    logic        redirect_valid, redirect_valid2;
    logic [31:0] redirect_target, redirect_target2;
    logic        fault, fault2;
    logic        misalign, misalign2;
    logic [15:0] fetch_count, fetch_count2;

    logic [31:0] mem [0:63];

    int errors = 0;
    int checks = 0;

    inst_fetch_unit_if bus1 ();
    inst_fetch_unit_if bus2 ();

    assign bus1.imem_instr = mem[bus1.imem_addr[7:2]];
    assign bus2.imem_instr = mem[bus2.imem_addr[7:2]];

    inst_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .bus             (bus1),
        .fault           (fault),
        .misalign        (misalign),
        .fetch_count     (fetch_count)
    );

    inst_fetch_unit #(.IMEM_DEPTH(8)) dut_small (
        .clk             (clk),
        .rst_n           (rst_n2),
        .fetch_en        (fetch_en2),
        .redirect_valid  (redirect_valid2),
        .redirect_target (redirect_target2),
        .bus             (bus2),
        .fault           (fault2),
        .misalign        (misalign2),
        .fetch_count     (fetch_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = word(i);
        rst_n = 1'b0;           rst_n2 = 1'b0;
        fetch_en = 1'b0;        fetch_en2 = 1'b0;
        redirect_valid = 1'b0;  redirect_valid2 = 1'b0;
        redirect_target = '0;   redirect_target2 = '0;
        bus1.out_ready = 1'b0;  bus2.out_ready = 1'b0;

        #2;
        check("rst_addr",   bus1.imem_addr, 32'h0);
        check("rst_valid",  bus1.out_valid, 32'h0);
        check("rst_instr",  bus1.out_instr, 32'h0);
        check("rst_pc",     bus1.out_pc, 32'h0);
        check("rst_pc4",    bus1.out_pc_plus4, 32'h0);
        check("rst_fault",  fault, 32'h0);
        check("rst_mis",    misalign, 32'h0);
        check("rst_count",  fetch_count, 32'h0);

        #10;
        rst_n = 1'b1; rst_n2 = 1'b1;
        fetch_en = 1'b1; bus1.out_ready = 1'b1;

        // first RUN cycle: address 0 presented, nothing registered yet
        step();
        check("run0_addr",  bus1.imem_addr, 32'h0);
        check("run0_valid", bus1.out_valid, 32'h0);

        // sequential fetch, IF/ID one cycle behind the address
        for (int m = 0; m <= 9; m++) begin
            step();
            check("seq_valid", bus1.out_valid, 32'h1);
            check("seq_pc",    bus1.out_pc, 32'(4 * m));
            check("seq_pc4",   bus1.out_pc_plus4, 32'(4 * m + 4));
            check("seq_instr", bus1.out_instr, word(m));
            check("seq_addr",  bus1.imem_addr, 32'(4 * m + 4));
            check("seq_count", fetch_count, 32'(m));
        end

        // redirect to 0 while handshaking; the handshake still counts
        redirect_valid = 1'b1; redirect_target = 32'h0;
        step();
        check("rd0_valid", bus1.out_valid, 32'h0);
        check("rd0_addr",  bus1.imem_addr, 32'h0);
        check("rd0_count", fetch_count, 32'd10);
        check("rd0_mis",   misalign, 32'h0);
        redirect_valid = 1'b0;
        step();
        check("rd0_pc_a", bus1.out_pc, 32'h0);
        step();
        check("rd0_pc_b", bus1.out_pc, 32'h4);
        step();
        check("rd0_pc_c",  bus1.out_pc, 32'h8);
        check("rd0_cnt_c", fetch_count, 32'd12);

        // three stalled cycles hold everything at out_pc 8
        bus1.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check("stall_valid", bus1.out_valid, 32'h1);
            check("stall_pc",    bus1.out_pc, 32'h8);
            check("stall_instr", bus1.out_instr, word(2));
            check("stall_addr",  bus1.imem_addr, 32'hC);
            check("stall_count", fetch_count, 32'd12);
        end
        bus1.out_ready = 1'b1;
        step();
        check("rel_pc",    bus1.out_pc, 32'hC);
        check("rel_instr", bus1.out_instr, word(3));
        check("rel_addr",  bus1.imem_addr, 32'h10);
        check("rel_count", fetch_count, 32'd13);

        // redirect during a stall flushes the held entry
        bus1.out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h14;
        step();
        check("rs_valid", bus1.out_valid, 32'h0);
        check("rs_addr",  bus1.imem_addr, 32'h14);
        check("rs_count", fetch_count, 32'd13);
        check("rs_mis",   misalign, 32'h0);
        redirect_valid = 1'b0; bus1.out_ready = 1'b1;
        step();
        check("rs_valid2", bus1.out_valid, 32'h1);
        check("rs_pc",     bus1.out_pc, 32'h14);
        check("rs_instr",  bus1.out_instr, word(5));
        check("rs_pc4",    bus1.out_pc_plus4, 32'h18);
        check("rs_mis2",   misalign, 32'h0);
        check("rs_count2", fetch_count, 32'd13);

        // misaligned target is rounded down and pulses misalign once
        redirect_valid = 1'b1; redirect_target = 32'h1A;
        step();
        check("ma_addr",  bus1.imem_addr, 32'h18);
        check("ma_mis",   misalign, 32'h1);
        check("ma_valid", bus1.out_valid, 32'h0);
        check("ma_count", fetch_count, 32'd14);
        redirect_valid = 1'b0;
        step();
        check("ma_mis2",  misalign, 32'h0);
        check("ma_pc",    bus1.out_pc, 32'h18);
        check("ma_instr", bus1.out_instr, word(6));

        // reach pc = 20, then assert reset mid-cycle
        redirect_valid = 1'b1; redirect_target = 32'h10;
        step();
        redirect_valid = 1'b0;
        step();
        check("pre_addr",  bus1.imem_addr, 32'h14);
        check("pre_count", fetch_count, 32'd15);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_addr",  bus1.imem_addr, 32'h0);
        check("mrst_valid", bus1.out_valid, 32'h0);
        check("mrst_count", fetch_count, 32'h0);
        check("mrst_fault", fault, 32'h0);
        check("mrst_pc",    bus1.out_pc, 32'h0);
        fetch_en = 1'b0;

        // small instance: run off the end of an 8-word memory
        fetch_en2 = 1'b1; bus2.out_ready = 1'b1;
        step();
        check("f_addr0", bus2.imem_addr, 32'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("f_pc",    bus2.out_pc, 32'(4 * k));
            check("f_instr", bus2.out_instr, word(k));
            check("f_addr",  bus2.imem_addr, 32'(4 * k + 4));
            check("f_fault", fault2, 32'h0);
        end
        for (int s = 0; s < 3; s++) begin
            step();
            check("flt_fault", fault2, 32'h1);
            check("flt_addr",  bus2.imem_addr, 32'h20);
            check("flt_valid", bus2.out_valid, 32'h0);
            check("flt_count", fetch_count2, 32'd8);
        end
        redirect_valid2 = 1'b1; redirect_target2 = 32'h0;
        step();
        check("fr_fault", fault2, 32'h0);
        check("fr_addr",  bus2.imem_addr, 32'h0);
        redirect_valid2 = 1'b0;
        step();
        check("fr_valid", bus2.out_valid, 32'h1);
        check("fr_pc",    bus2.out_pc, 32'h0);
        check("fr_instr", bus2.out_instr, word(0));
        check("fr_addr2", bus2.imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
